muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 27 ++
 rtl/div_step.sv | 36 +++
 rtl/muldiv_ctrl.sv | 160 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// ============================================================================
// Module      : muldiv_ctrl_pkg
// Description : Shared RV32M divide constants and divider FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OP2_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNC_DIV  = 3'b100;
  localparam logic [2:0] FUNC_DIVU = 3'b101;
  localparam logic [2:0] FUNC_REM  = 3'b110;
  localparam logic [2:0] FUNC_REMU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational unsigned restoring-division iteration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] divisor_i,
  output logic [W:0]   rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] w_shift;
  logic [W:0] w_diff;

  always_comb begin
    w_shift = {rem_i[W-1:0], quo_i[W-1]};
    w_diff  = w_shift - {1'b0, divisor_i};
    // A set top bit means the trial subtraction went negative: restore.
    if (w_diff[W]) begin
      rem_o = w_shift;
      quo_o = {quo_i[W-2:0], 1'b0};
    end else begin
      rem_o = w_diff;
      quo_o = {quo_i[W-2:0], 1'b1};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// ============================================================================
// Module      : muldiv_ctrl
// Description : Multi-cycle RV32M DIV/DIVU/REM/REMU unit with pipeline stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func,
  input  logic [XLEN-1:0] din1,
  input  logic [XLEN-1:0] din2,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] dout
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   div_q, div_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic              isrem_q, isrem_d;
  logic [XLEN-1:0]   dout_q, dout_d;

  logic              w_accept;
  logic              w_signed;
  logic              w_neg1;
  logic              w_neg2;
  logic              w_dz;
  logic              w_ovf;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic [XLEN:0]     w_rem_nxt;
  logic [XLEN-1:0]   w_quo_nxt;
  logic [XLEN-1:0]   w_fixed;

  div_step #(.W(XLEN)) u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (div_q),
    .rem_o     (w_rem_nxt),
    .quo_o     (w_quo_nxt)
  );

  always_comb begin
    w_accept = (state_q == ST_IDLE) && start && func[2];
    w_signed = ~func[0];
    w_neg1   = w_signed & din1[XLEN-1];
    w_neg2   = w_signed & din2[XLEN-1];
    w_mag1   = w_neg1 ? -din1 : din1;
    w_mag2   = w_neg2 ? -din2 : din2;
    w_dz     = (din2 == '0);
    w_ovf    = w_signed && (din1 == INT_MIN) && (din2 == '1);
    if (isrem_q) begin
      w_fixed = negr_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    end else begin
      w_fixed = negq_q ? -quo_q : quo_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    isrem_d = isrem_q;
    dout_d  = dout_q;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          isrem_d = func[1];
          negq_d  = w_neg1 ^ w_neg2;
          negr_d  = w_neg1;
          // Corner cases resolve immediately and bypass the iteration loop.
          if (w_dz) begin
            dout_d  = func[1] ? din1 : '1;
            state_d = ST_DONE;
          end else if (w_ovf) begin
            dout_d  = func[1] ? '0 : INT_MIN;
            state_d = ST_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = w_mag1;
            div_d   = w_mag2;
            cnt_d   = '0;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        rem_d = w_rem_nxt;
        quo_d = w_quo_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        dout_d  = w_fixed;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      isrem_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      isrem_q <= isrem_d;
      dout_q  <= dout_d;
    end
  end

  assign stall = rst_n & (w_accept | (state_q == ST_CALC) | (state_q == ST_FIX));
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign dout  = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Directed self-checking bench for the muldiv_ctrl divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  func;
  logic [31:0] din1;
  logic [31:0] din2;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] dout;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_ctrl #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .func  (func),
    .din1  (din1),
    .din2  (din2),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called #1 after the accept edge; scrambles inputs to prove they were latched.
  task automatic wait_done(input string tag, input int lat, input logic [31:0] exp,
                           input int stall_exp);
    int n;
    int sc;
    bit seen;
    n = 0;
    sc = 0;
    seen = 1'b0;
    din1 = 32'hDEAD_BEEF;
    din2 = 32'h0;
    while (n < 60 && !seen) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      else if (stall) sc++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_dout"}, dout, exp);
    chk({tag, "_stall"}, 32'(sc), 32'(stall_exp));
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, done}, 32'h0);
    chk({tag, "_idle"}, {31'b0, busy}, 32'h0);
    chk({tag, "_hold"}, dout, exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit fast);
    @(negedge clk);
    start = 1'b1;
    func  = f;
    din1  = a;
    din2  = b;
    #1;
    chk({tag, "_acc_stall"}, {31'b0, stall}, 32'h1);
    @(posedge clk);
    #1;
    start = 1'b0;
    func  = 3'b000;
    wait_done(tag, fast ? 1 : 34, exp, fast ? 0 : 33);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    func  = 3'b000;
    din1  = '0;
    din2  = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", dout, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    start = 1'b1;
    func  = 3'b101;
    din1  = 32'd9;
    din2  = 32'd3;
    #1;
    chk("rst_stall", {31'b0, stall}, 32'h0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_op("divu_100_7",  3'b101, 32'd100,        32'd7,          32'd14,         1'b0);
    run_op("remu_100_7",  3'b111, 32'd100,        32'd7,          32'd2,          1'b0);
    run_op("div_m100_7",  3'b100, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0);
    run_op("rem_m100_7",  3'b110, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  1'b0);
    run_op("div_100_m7",  3'b100, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  1'b0);
    run_op("rem_100_m7",  3'b110, 32'd100,        32'hFFFF_FFF9,  32'd2,          1'b0);
    run_op("divu_7_100",  3'b101, 32'd7,          32'd100,        32'd0,          1'b0);
    run_op("remu_7_100",  3'b111, 32'd7,          32'd100,        32'd7,          1'b0);
    run_op("divu_max_1",  3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0);
    run_op("divu_min_m1", 3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0);
    run_op("remu_min_m1", 3'b111, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0);
    run_op("div_min_1",   3'b100, 32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0);
    run_op("divu_5_0",    3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1);
    run_op("remu_5_0",    3'b111, 32'd5,          32'd0,          32'd5,          1'b1);
    run_op("div_m7_0",    3'b100, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  1'b1);
    run_op("rem_m7_0",    3'b110, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1'b1);
    run_op("div_ovf",     3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1);
    run_op("rem_ovf",     3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1);

    // Start held through CALC and DONE: only the following IDLE cycle accepts.
    @(negedge clk);
    start = 1'b1;
    func  = 3'b101;
    din1  = 32'd100;
    din2  = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b1;
    wait_done("held", 34, 32'd14, 33);
    chk("held_reaccept", {31'b0, stall}, 32'h1);
    func = 3'b101;
    din1 = 32'd50;
    din2 = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("held2", 34, 32'd10, 33);

    // Non-divide funct3 is never taken.
    @(negedge clk);
    start = 1'b1;
    func  = 3'b000;
    #1;
    chk("f000_stall", {31'b0, stall}, 32'h0);
    @(negedge clk);
    chk("f000_busy", {31'b0, busy}, 32'h0);
    func = 3'b011;
    #1;
    chk("f011_stall", {31'b0, stall}, 32'h0);
    @(negedge clk);
    chk("f011_busy", {31'b0, busy}, 32'h0);
    start = 1'b0;

    // Reset in the middle of CALC abandons the operation.
    @(negedge clk);
    start = 1'b1;
    func  = 3'b101;
    din1  = 32'd100;
    din2  = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_stall", {31'b0, stall}, 32'h0);
    chk("mid_rst_dout", dout, 32'h0);
    chk("mid_rst_done", {31'b0, done}, 32'h0);
    rst_n = 1'b1;
    run_op("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
